// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and sizing shared by the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int DATA_W   = 32;
    localparam int ITER_CNT = 32;
    localparam int CNT_W    = $clog2(ITER_CNT);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    function automatic logic op_is_mul(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: restoring divider on unsigned magnitudes, one quotient bit per step.
module muldiv_div_core
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] dsr_q;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W-1:0] rem_diff;
    logic              fits;

    // The partial remainder can need one extra bit after the shift; the difference never does
    always_comb begin
        rem_shift = {rem_q, quo_q[DATA_W-1]};
        fits      = (rem_shift >= {1'b0, dsr_q});
        rem_diff  = rem_shift[DATA_W-1:0] - dsr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
        end else if (step) begin
            quo_q <= {quo_q[DATA_W-2:0], fits};
            rem_q <= fits ? rem_diff : rem_shift[DATA_W-1:0];
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide with sign fix-up, flush, and direct HI/LO writes.
// Define MULDIV_FAST_MULT_EN for a single-cycle combinational multiply (divide unaffected).
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    input  logic              we_hi,
    input  logic              we_lo,
    input  logic [DATA_W-1:0] hi_wdata,
    input  logic [DATA_W-1:0] lo_wdata,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    state_e              state;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          op_q;
    logic                neg_res;
    logic                neg_rem;
    logic                dz;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   mcand;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic                accept;
    logic                mul_op;
    logic                calc_last;
    logic                div_step;
    logic                commit;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic [DATA_W-1:0]   fix_hi;
    logic [DATA_W-1:0]   fix_lo;
`ifndef MULDIV_FAST_MULT_EN
    logic [DATA_W:0]     mul_sum;
`endif

    // Magnitude of the most negative value is its own bit pattern read as unsigned
    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                    input logic is_signed);
        return (is_signed && v[DATA_W-1]) ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [DATA_W-1:0] sign_fix(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] sign_fix_wide(input logic [2*DATA_W-1:0] v,
                                                          input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    always_comb begin
        accept   = (state == ST_IDLE) && start;
        mul_op   = op_is_mul(op_q);
        div_step = (state == ST_CALC) && !mul_op;
        mag_a    = magnitude(src_a, op_is_signed(op));
        mag_b    = magnitude(src_b, op_is_signed(op));
`ifdef MULDIV_FAST_MULT_EN
        calc_last = mul_op ? 1'b1 : (cnt == CNT_W'(ITER_CNT - 1));
`else
        calc_last = (cnt == CNT_W'(ITER_CNT - 1));
        mul_sum   = {1'b0, prod[2*DATA_W-1:DATA_W]} + {1'b0, {DATA_W{prod[0]}} & mcand};
`endif
        commit   = (state == ST_FIX) && !flush && !dz;
        prod_fix = sign_fix_wide(prod, neg_res);
        quo_fix  = sign_fix(quo, neg_res);
        rem_fix  = sign_fix(rem, neg_rem);
        fix_hi   = mul_op ? prod_fix[2*DATA_W-1:DATA_W] : rem_fix;
        fix_lo   = mul_op ? prod_fix[DATA_W-1:0]        : quo_fix;
    end

    muldiv_div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            op_q    <= OP_MULT;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            prod    <= '0;
            mcand   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_CALC;
                        cnt     <= '0;
                        op_q    <= op;
                        neg_res <= op_is_signed(op) && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                        neg_rem <= op_is_signed(op) && src_a[DATA_W-1];
                        dz      <= !op_is_mul(op) && (src_b == '0);
                        prod    <= {{DATA_W{1'b0}}, mag_a};
                        mcand   <= mag_b;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (calc_last) begin
                        state <= ST_FIX;
                    end
                    cnt <= cnt + 1'b1;
                    // Multiplier bits are consumed from the low half while the product grows in from the top
                    if (mul_op) begin
`ifdef MULDIV_FAST_MULT_EN
                        prod <= {{DATA_W{1'b0}}, prod[DATA_W-1:0]} * {{DATA_W{1'b0}}, mcand};
`else
                        prod <= {mul_sum, prod[DATA_W-1:1]};
`endif
                    end
                end
                ST_FIX: begin
                    state <= flush ? ST_IDLE : ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The FIX commit takes priority over a same-edge direct write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end else begin
            if (we_hi) begin
                hi_q <= hi_wdata;
            end
            if (we_lo) begin
                lo_q <= lo_wdata;
            end
        end
    end

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign div_by_zero = (state == ST_DONE) && dz;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_L = 1;
`else
    localparam int MUL_L = 32;
`endif
    localparam int DIV_L = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        we_hi = 1'b0;
    logic        we_lo = 1'b0;
    logic [31:0] hi_wdata = '0;
    logic [31:0] lo_wdata = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    muldiv_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .we_hi       (we_hi),
        .we_lo       (we_lo),
        .hi_wdata    (hi_wdata),
        .lo_wdata    (lo_wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the ISA rules
    task automatic ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] rh, output logic [31:0] rl, output bit z);
        longint sa, sb, p, q, r;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        z  = 1'b0;
        rh = '0;
        rl = '0;
        case (o)
            OP_MULT: begin
                p  = sa * sb;
                rh = p[63:32];
                rl = p[31:0];
            end
            OP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                rh = up[63:32];
                rl = up[31:0];
            end
            OP_DIV: begin
                if (b == 0) z = 1'b1;
                else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    rl = q[31:0];
                    rh = r[31:0];
                end
            end
            default: begin
                if (b == 0) z = 1'b1;
                else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
        endcase
    endtask

    // Model: an op is a countdown of cycles since acceptance; commit happens on its FIX edge
    bit          m_busy = 1'b0;
    int          m_age = 0;
    int          m_len = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_rhi = '0;
    logic [31:0] m_rlo = '0;
    bit          m_rdz = 1'b0;
    bit          m_done = 1'b0;
    bit          m_dz = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_done = 1'b0;
            m_dz   = 1'b0;
        end else begin
            bit nd, ndz;
            nd  = 1'b0;
            ndz = 1'b0;
            if (we_hi) m_hi = hi_wdata;
            if (we_lo) m_lo = lo_wdata;
            if (m_busy) begin
                if (m_age <= m_len && flush) begin
                    m_busy = 1'b0;
                end else if (m_age == m_len) begin
                    nd  = 1'b1;
                    ndz = m_rdz;
                    if (!m_rdz) begin
                        m_hi = m_rhi;
                        m_lo = m_rlo;
                    end
                    m_age++;
                end else if (m_age == m_len + 1) begin
                    m_busy = 1'b0;
                end else begin
                    m_age++;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_len  = (op == OP_MULT || op == OP_MULTU) ? MUL_L : DIV_L;
                ref_result(op, src_a, src_b, m_rhi, m_rlo, m_rdz);
            end
            m_done = nd;
            m_dz   = ndz;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dz});
            chk("hi_out", hi_out, m_hi);
            chk("lo_out", lo_out, m_lo);
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    task automatic wait_idle();
        for (int k = 0; k < 100 && busy; k++) begin
            @(posedge clk);
            #1;
        end
        if (busy) chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // lat is the cycle index of done, counting the cycle right after the start edge as 1
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k + 1;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        wait_idle();
        launch(o, a, b);
        wait_done(lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        #3 rst = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);

        // Start is already up when reset releases: the first edge must accept it
        rst = 1'b1;
        do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, lat);
        chk("mult_lat", 32'(lat), 32'(MUL_L + 2));
        chk("mult_hi", hi_out, 32'hFFFF_FFFF);
        chk("mult_lo", lo_out, 32'hFFFF_FFFA);

        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
        chk("div_lat", 32'(lat), 32'd34);
        chk("div_lo", lo_out, 32'hFFFF_FFFD);
        chk("div_hi", hi_out, 32'hFFFF_FFFF);

        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("div_ovf_lo", lo_out, 32'h8000_0000);
        chk("div_ovf_hi", hi_out, 32'h0000_0000);
        chk("div_ovf_dz", {31'd0, div_by_zero}, 32'd0);

        wait_idle();
        we_hi = 1'b1; hi_wdata = 32'h11;
        we_lo = 1'b1; lo_wdata = 32'h22;
        @(posedge clk);
        #1;
        we_hi = 1'b0;
        we_lo = 1'b0;
        do_op(OP_DIVU, 32'd100, 32'd0, lat);
        chk("dz_lat", 32'(lat), 32'd34);
        chk("dz_flag", {31'd0, div_by_zero}, 32'd1);
        chk("dz_hi", hi_out, 32'h11);
        chk("dz_lo", lo_out, 32'h22);

        // Flush during CALC, then restart one cycle later
        wait_idle();
        launch(OP_DIVU, 32'hFFFF_FFFF, 32'h10);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        chk("flush_hi", hi_out, 32'h11);
        chk("flush_lo", lo_out, 32'h22);
        launch(OP_MULTU, 32'd7, 32'd9);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        wait_done(lat);
        chk("restart_lo", lo_out, 32'd63);
        chk("restart_hi", hi_out, 32'd0);

        // Ignored second start and a direct LO write colliding with the FIX commit
        wait_idle();
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int t = 1; t <= MUL_L + 1; t++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            we_lo = 1'b0;
            if (t == 4 && MUL_L > 5) begin
                start = 1'b1;
                op    = OP_DIVU;
                src_a = 32'd5;
                src_b = 32'd1;
            end
            if (t == MUL_L) begin
                we_lo    = 1'b1;
                lo_wdata = 32'h55;
            end
        end
        chk("collide_done", {31'd0, done}, 32'd1);
        chk("collide_hi", hi_out, 32'hFFFF_FFFE);
        chk("collide_lo", lo_out, 32'h0000_0001);

        // Asynchronous reset in the middle of a divide
        wait_idle();
        launch(OP_DIV, 32'd1000, 32'd7);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_dz", {31'd0, div_by_zero}, 32'd0);
        chk("arst_hi", hi_out, 32'd0);
        chk("arst_lo", lo_out, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        do_op(OP_MULTU, 32'd2, 32'd3, lat);
        chk("post_rst_lo", lo_out, 32'd6);
        chk("post_rst_hi", hi_out, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            start    = ($urandom_range(0, 3) == 0);
            op       = 2'($urandom_range(0, 3));
            src_a    = pick();
            src_b    = pick();
            flush    = ($urandom_range(0, 149) == 0);
            we_hi    = ($urandom_range(0, 11) == 0);
            we_lo    = ($urandom_range(0, 11) == 0);
            hi_wdata = $urandom();
            lo_wdata = $urandom();
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        we_hi = 1'b0;
        we_lo = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
